// File: rtl/mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe
//
// MEM -> WB pipeline register with a two-entry skid buffer. Loads are
// extracted and sign/zero-extended when an entry is captured, so the
// write-back value is driven straight from a register.
//
// Parameters
//   DATA_W : datapath width (32 or 64)
//   REG_W  : register-address width
//   CNT_W  : retire-counter width
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_valid        : upstream MEM entry is valid
//   in_ready        : an entry can be accepted this cycle (register-only)
//   control_wb_in   : [0] regwrite, [1] memtoreg
//   load_size_in    : 00 byte, 01 half, 1x full width
//   load_signed_in  : sign-extend sub-word loads
//   byte_off_in     : byte offset of the load within the low 32 bits
//   read_data_in    : memory read data
//   alu_result_in   : ALU result
//   write_reg_in    : destination register
//   flush           : discard all held and incoming entries
//   out_valid       : WB entry presented
//   out_ready       : WB consumes the presented entry this cycle
//   regwrite        : presented entry writes a register (0 when idle)
//   memtoreg        : presented entry is a load (0 when idle)
//   wb_data         : write-back value of the presented entry
//   wb_reg          : destination register of the presented entry
//   fwd_en          : out_valid & regwrite, for forwarding logic
//   retire_count    : wrapping count of retired register-writing entries
// -----------------------------------------------------------------------------
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        control_wb_in,
  input  logic [1:0]        load_size_in,
  input  logic              load_signed_in,
  input  logic [1:0]        byte_off_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [REG_W-1:0]  write_reg_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              regwrite,
  output logic              memtoreg,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_reg,
  output logic              fwd_en,
  output logic [CNT_W-1:0]  retire_count
);

  // One pipeline entry as it will be presented to WB.
  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
  } entry_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  entry_t            prim_q;
  entry_t            skid_q;
  entry_t            in_entry;
  logic              prim_valid;
  logic              skid_valid;
  logic              consume;
  logic              accept;
  logic              prim_free;
  logic              to_prim;
  logic              to_skid;
  logic [CNT_W-1:0]  count_q;

  // ---------------------------------------------------------------------------
  // Load extraction and extension. Sub-word fields always come from the
  // low 32 bits; a half-word ignores the low offset bit.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] extend_load(
    input logic [1:0]        size,
    input logic              sgn,
    input logic [1:0]        off,
    input logic [DATA_W-1:0] rdata
  );
    logic [31:0]       low;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [DATA_W-1:0] result;
    low      = rdata[31:0];
    byte_val = low[{off, 3'b000} +: 8];
    half_val = off[1] ? low[31:16] : low[15:0];
    case (size)
      SIZE_BYTE: result = {{(DATA_W-8){sgn & byte_val[7]}}, byte_val};
      SIZE_HALF: result = {{(DATA_W-16){sgn & half_val[15]}}, half_val};
      default:   result = rdata;
    endcase
    return result;
  endfunction

  // ---------------------------------------------------------------------------
  // Incoming entry, fully formed before capture.
  // ---------------------------------------------------------------------------
  // NOTE: every field gets a value on every path through an always_comb;
  // a field left unassigned on some path would infer a latch.
  always_comb begin
    in_entry          = '0;
    // Register zero is hard-wired, so a write to it is dropped here.
    in_entry.regwrite = control_wb_in[0] & (write_reg_in != '0);
    in_entry.memtoreg = control_wb_in[1];
    in_entry.rd       = write_reg_in;
    if (control_wb_in[1]) begin
      in_entry.data = extend_load(load_size_in, load_signed_in,
                                  byte_off_in, read_data_in);
    end else begin
      in_entry.data = alu_result_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake. in_ready depends only on the skid valid bit, which keeps
  // out_ready off any combinational path to the upstream stage.
  // ---------------------------------------------------------------------------
  assign in_ready  = ~skid_valid;
  assign consume   = prim_valid & out_ready;
  assign accept    = in_valid & ~skid_valid & ~flush;
  assign prim_free = ~prim_valid | consume;
  // Primary only takes the new entry when nothing older is waiting in skid.
  assign to_prim   = accept & prim_free & ~skid_valid;
  assign to_skid   = accept & ~to_prim;

  // ---------------------------------------------------------------------------
  // Valid bits and primary payload.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prim_valid <= 1'b0;
      skid_valid <= 1'b0;
      prim_q     <= '0;
    end else if (flush) begin
      // Payload is left alone; the cleared valid bits already hide it.
      prim_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (prim_free) begin
        if (skid_valid) begin
          prim_valid <= 1'b1;
          prim_q     <= skid_q;
        end else if (accept) begin
          prim_valid <= 1'b1;
          prim_q     <= in_entry;
        end else begin
          prim_valid <= 1'b0;
        end
      end
      skid_valid <= (skid_valid & ~prim_free) | to_skid;
    end
  end

  // NOTE: the skid payload has no reset; skid_valid gates it, and it is
  // never observed on an output without first passing through primary.
  always_ff @(posedge clk) begin
    if (to_skid && !flush && !rst) begin
      skid_q <= in_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Retire counter. A consume on a flush cycle still retires the entry
  // that WB took, so flush is deliberately absent here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (consume && prim_q.regwrite) begin
      count_q <= count_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Control bits are masked by valid so an idle stage never
  // advertises a write.
  // ---------------------------------------------------------------------------
  assign out_valid    = prim_valid;
  assign regwrite     = prim_valid & prim_q.regwrite;
  assign memtoreg     = prim_valid & prim_q.memtoreg;
  assign fwd_en       = prim_valid & prim_q.regwrite;
  assign wb_data      = prim_q.data;
  assign wb_reg       = prim_q.rd;
  assign retire_count = count_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_pipe
//
// Scoreboard bench for mem_wb_pipe (DATA_W=32, REG_W=5, CNT_W=4 so the
// retire counter wraps quickly). The driver pushes the expected WB entry
// for every accepted input into a queue; a monitor on the falling edge
// compares the presented entry with the queue head and pops on consume.
// -----------------------------------------------------------------------------
module tb_mem_wb_pipe;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        control_wb_in = '0;
  logic [1:0]        load_size_in = '0;
  logic              load_signed_in = 1'b0;
  logic [1:0]        byte_off_in = '0;
  logic [DATA_W-1:0] read_data_in = '0;
  logic [DATA_W-1:0] alu_result_in = '0;
  logic [REG_W-1:0]  write_reg_in = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              regwrite;
  logic              memtoreg;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_reg;
  logic              fwd_en;
  logic [CNT_W-1:0]  retire_count;

  mem_wb_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .control_wb_in  (control_wb_in),
    .load_size_in   (load_size_in),
    .load_signed_in (load_signed_in),
    .byte_off_in    (byte_off_in),
    .read_data_in   (read_data_in),
    .alu_result_in  (alu_result_in),
    .write_reg_in   (write_reg_in),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .regwrite       (regwrite),
    .memtoreg       (memtoreg),
    .wb_data        (wb_data),
    .wb_reg         (wb_reg),
    .fwd_en         (fwd_en),
    .retire_count   (retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rw;
    bit        mtr;
    bit [31:0] data;
    bit [4:0]  rd;
  } exp_t;

  typedef struct {
    bit        iv;
    bit [1:0]  ctrl;
    bit [1:0]  sz;
    bit        sg;
    bit [1:0]  off;
    bit [31:0] rd;
    bit [31:0] alu;
    bit [4:0]  wr;
    bit        fl;
    bit        ordy;
    bit        r;
  } stim_t;

  exp_t exp_q[$];
  int   exp_count = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: what WB should see for one MEM entry.
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    int unsigned v;
    v = s.rd;
    if (s.sz == 2'd0) begin
      v = (s.rd >> (8 * int'(s.off))) & 32'hFF;
      if (s.sg && v >= 128) v = v - 256;
    end else if (s.sz == 2'd1) begin
      v = (s.rd >> ((s.off >= 2) ? 16 : 0)) & 32'hFFFF;
      if (s.sg && v >= 32768) v = v - 65536;
    end
    e.mtr  = s.ctrl[1];
    e.rw   = s.ctrl[0] && (s.wr != 0);
    e.data = s.ctrl[1] ? v : s.alu;
    e.rd   = s.wr;
    return e;
  endfunction

  function automatic stim_t idle(input bit ordy);
    stim_t s;
    s      = '{default: '0};
    s.ordy = ordy;
    return s;
  endfunction

  function automatic stim_t alu_op(input bit [31:0] alu, input bit [4:0] wr, input bit ordy);
    stim_t s;
    s      = idle(ordy);
    s.iv   = 1'b1;
    s.ctrl = 2'b01;
    s.alu  = alu;
    s.wr   = wr;
    return s;
  endfunction

  function automatic stim_t load_op(input bit [1:0] sz, input bit sg, input bit [1:0] off,
                                    input bit [31:0] rd, input bit [4:0] wr, input bit ordy);
    stim_t s;
    s      = idle(ordy);
    s.iv   = 1'b1;
    s.ctrl = 2'b11;
    s.sz   = sz;
    s.sg   = sg;
    s.off  = off;
    s.rd   = rd;
    s.alu  = 32'h0BAD_0BAD;
    s.wr   = wr;
    return s;
  endfunction

  // Drive one cycle (called at posedge+1), then update the model with the
  // effect of the edge. Consumes are popped by the monitor before the edge.
  task automatic step(input stim_t s, output bit acc);
    exp_t e;
    in_valid       = s.iv;
    control_wb_in  = s.ctrl;
    load_size_in   = s.sz;
    load_signed_in = s.sg;
    byte_off_in    = s.off;
    read_data_in   = s.rd;
    alu_result_in  = s.alu;
    write_reg_in   = s.wr;
    flush          = s.fl;
    out_ready      = s.ordy;
    rst            = s.r;
    acc = !s.r && s.iv && !s.fl && (exp_q.size() < 2);
    e   = model(s);
    @(posedge clk);
    #1;
    if (s.r) begin
      exp_q.delete();
      exp_count = 0;
    end else begin
      if (s.fl) exp_q.delete();
      if (acc) exp_q.push_back(e);
    end
  endtask

  task automatic go(input stim_t s);
    bit acc;
    step(s, acc);
  endtask

  task automatic do_reset();
    stim_t s;
    s   = idle(1'b0);
    s.r = 1'b1;
    go(s);
    go(s);
    rst = 1'b0;
  endtask

  // Keep presenting s until accepted (bounded), then drop in_valid.
  task automatic push_until_accepted(input stim_t s, input string name);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) step(s, acc);
    if (!acc) check({name, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compare presented state with the model on every falling edge.
  // ---------------------------------------------------------------------------
  initial begin
    exp_t h;
    bit   has;
    forever begin
      @(negedge clk);
      if (!rst) begin
        has = exp_q.size() > 0;
        if (has) h = exp_q[0];
        check("in_ready", in_ready, (exp_q.size() < 2) ? 64'd1 : 64'd0);
        check("out_valid", out_valid, has ? 64'd1 : 64'd0);
        check("regwrite", regwrite, (has && h.rw) ? 64'd1 : 64'd0);
        check("memtoreg", memtoreg, (has && h.mtr) ? 64'd1 : 64'd0);
        check("fwd_en", fwd_en, (has && h.rw) ? 64'd1 : 64'd0);
        check("retire_count", retire_count, 64'(exp_count));
        if (has) begin
          check("wb_data", wb_data, 64'(h.data));
          check("wb_reg", wb_reg, 64'(h.rd));
        end
        if (out_valid && out_ready) begin
          if (!has) begin
            check("spurious_output", 64'd1, 64'd0);
          end else begin
            void'(exp_q.pop_front());
            if (h.rw) exp_count = (exp_count + 1) % (1 << CNT_W);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    stim_t s;
    #1;
    do_reset();
    check("rst_in_ready", in_ready, 64'd1);
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_count", retire_count, 64'd0);

    // Word load, then retirement.
    go(load_op(2'b10, 1'b0, 2'd0, 32'hDEADBEEF, 5'd7, 1'b1));
    check("word_data", wb_data, 64'hDEADBEEF);
    check("word_reg", wb_reg, 64'd7);
    check("word_rw", regwrite, 64'd1);
    check("word_count_before", retire_count, 64'd0);
    go(idle(1'b1));
    check("word_count_after", retire_count, 64'd1);

    // Sub-word loads, back to back at full throughput.
    go(load_op(2'b00, 1'b1, 2'd0, 32'h12345680, 5'd3, 1'b1));
    check("byte_signed", wb_data, 64'hFFFFFF80);
    go(load_op(2'b00, 1'b0, 2'd0, 32'h12345680, 5'd3, 1'b1));
    check("byte_unsigned", wb_data, 64'h00000080);
    go(load_op(2'b01, 1'b1, 2'd2, 32'h80010000, 5'd4, 1'b1));
    check("half_signed", wb_data, 64'hFFFF8001);
    go(idle(1'b1));

    // Backpressure: A to primary, B to skid, C stalls.
    go(alu_op(32'hA, 5'd10, 1'b0));
    go(alu_op(32'hB, 5'd11, 1'b0));
    check("bp_in_ready", in_ready, 64'd0);
    go(alu_op(32'hC, 5'd12, 1'b0));
    check("bp_hold_a", wb_data, 64'hA);
    push_until_accepted(alu_op(32'hC, 5'd12, 1'b1), "bp_c");
    for (int i = 0; i < 3; i++) go(idle(1'b1));
    check("bp_drained", out_valid, 64'd0);

    // Flush with both entries full and an incoming entry.
    go(alu_op(32'h1, 5'd1, 1'b0));
    go(alu_op(32'h2, 5'd2, 1'b0));
    s    = alu_op(32'h3, 5'd3, 1'b0);
    s.fl = 1'b1;
    go(s);
    check("flush_out_valid", out_valid, 64'd0);
    check("flush_in_ready", in_ready, 64'd1);
    check("flush_count", retire_count, 64'(exp_count));
    go(idle(1'b1));

    // Register zero never writes.
    go(alu_op(32'h55, 5'd0, 1'b1));
    check("r0_regwrite", regwrite, 64'd0);
    check("r0_fwd_en", fwd_en, 64'd0);
    go(idle(1'b1));

    // Counter wrap at 16 retires.
    do_reset();
    for (int i = 0; i < 16; i++) go(alu_op(32'(i), 5'(1 + i), 1'b1));
    check("wrap_15", retire_count, 64'd15);
    go(idle(1'b1));
    check("wrap_0", retire_count, 64'd0);

    // Reset mid-stream with both entries valid, overriding flush/accept/consume.
    go(alu_op(32'h77, 5'd9, 1'b0));
    go(alu_op(32'h88, 5'd9, 1'b0));
    s    = alu_op(32'h99, 5'd9, 1'b1);
    s.fl = 1'b1;
    s.r  = 1'b1;
    go(s);
    check("mrst_out_valid", out_valid, 64'd0);
    check("mrst_regwrite", regwrite, 64'd0);
    check("mrst_memtoreg", memtoreg, 64'd0);
    check("mrst_fwd_en", fwd_en, 64'd0);
    check("mrst_wb_data", wb_data, 64'd0);
    check("mrst_wb_reg", wb_reg, 64'd0);
    check("mrst_count", retire_count, 64'd0);
    rst = 1'b0;
    check("mrst_in_ready", in_ready, 64'd1);
    go(idle(1'b1));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s.iv   = $urandom_range(0, 3) != 0;
      s.ctrl = 2'($urandom_range(0, 3));
      s.sz   = 2'($urandom_range(0, 3));
      s.sg   = 1'($urandom_range(0, 1));
      s.off  = 2'($urandom_range(0, 3));
      s.rd   = $urandom;
      s.alu  = $urandom;
      s.wr   = 5'($urandom_range(0, 31));
      s.fl   = $urandom_range(0, 49) == 0;
      s.ordy = $urandom_range(0, 9) < 7;
      s.r    = $urandom_range(0, 299) == 0;
      go(s);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) go(idle(1'b1));
    check("final_empty", out_valid, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
